// File: rtl/dot_vector_feeder.sv
// rtl/dot_vector_feeder.sv - streams paired vector elements from two memories into a dot-product engine
module dot_vector_feeder #(
    parameter int DATA_WIDTH   = 8,
    parameter int VECTOR_WIDTH = 4,
    parameter int ADDR_WIDTH   = 5,
    parameter int COUNT_WIDTH  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic [ADDR_WIDTH-1:0]  base_a,
    input  logic [ADDR_WIDTH-1:0]  base_b,
    input  logic [COUNT_WIDTH-1:0] num_vectors,
    output logic                   mem1_en,
    output logic [ADDR_WIDTH-1:0]  mem1_addr,
    input  logic [DATA_WIDTH-1:0]  mem1_rdata,
    output logic                   mem2_en,
    output logic [ADDR_WIDTH-1:0]  mem2_addr,
    input  logic [DATA_WIDTH-1:0]  mem2_rdata,
    output logic [DATA_WIDTH-1:0]  out_a,
    output logic [DATA_WIDTH-1:0]  out_b,
    output logic                   out_valid,
    input  logic                   result_valid,
    output logic                   busy,
    output logic                   done,
    output logic [COUNT_WIDTH-1:0] vectors_done,
    output logic                   protocol_err
);

    localparam int EW = $clog2(VECTOR_WIDTH);
    localparam logic [EW-1:0] LAST_ELEM = EW'(VECTOR_WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT_RES,
        S_DONE
    } state_t;

    state_t                 state;
    logic [ADDR_WIDTH-1:0]  cur_a;
    logic [ADDR_WIDTH-1:0]  cur_b;
    logic [COUNT_WIDTH-1:0] num_lat;
    logic [EW-1:0]          elem_idx;
    logic                   en_d;
    logic [COUNT_WIDTH-1:0] vectors_done_nx;

    assign vectors_done_nx = vectors_done + 1'b1;

    // cur_a/cur_b run continuously, so after a burst they already point at the next vector
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            cur_a        <= '0;
            cur_b        <= '0;
            num_lat      <= '0;
            elem_idx     <= '0;
            en_d         <= 1'b0;
            mem1_en      <= 1'b0;
            mem2_en      <= 1'b0;
            mem1_addr    <= '0;
            mem2_addr    <= '0;
            out_a        <= '0;
            out_b        <= '0;
            out_valid    <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            vectors_done <= '0;
            protocol_err <= 1'b0;
        end else begin
            done      <= 1'b0;
            en_d      <= mem1_en;
            out_valid <= en_d;
            if (en_d) begin
                out_a <= mem1_rdata;
                out_b <= mem2_rdata;
            end

            if (state == S_IDLE) begin
                mem1_en <= 1'b0;
                mem2_en <= 1'b0;
                if (start) begin
                    cur_a        <= base_a;
                    cur_b        <= base_b;
                    num_lat      <= num_vectors;
                    elem_idx     <= '0;
                    vectors_done <= '0;
                    protocol_err <= 1'b0;
                    busy         <= 1'b1;
                    state        <= (num_vectors == '0) ? S_DONE : S_FETCH;
                end else if (result_valid) begin
                    protocol_err <= 1'b1;
                end
            end else if (abort) begin
                // drop the in-flight read so no partial element reaches the engine
                state     <= S_IDLE;
                busy      <= 1'b0;
                mem1_en   <= 1'b0;
                mem2_en   <= 1'b0;
                en_d      <= 1'b0;
                out_valid <= 1'b0;
            end else begin
                unique case (state)
                    S_FETCH: begin
                        mem1_en   <= 1'b1;
                        mem2_en   <= 1'b1;
                        mem1_addr <= cur_a;
                        mem2_addr <= cur_b;
                        cur_a     <= cur_a + 1'b1;
                        cur_b     <= cur_b + 1'b1;
                        if (elem_idx == LAST_ELEM) begin
                            elem_idx <= '0;
                            state    <= S_WAIT_RES;
                        end else begin
                            elem_idx <= elem_idx + 1'b1;
                        end
                        if (result_valid) begin
                            protocol_err <= 1'b1;
                        end
                    end
                    S_WAIT_RES: begin
                        mem1_en <= 1'b0;
                        mem2_en <= 1'b0;
                        if (result_valid) begin
                            vectors_done <= vectors_done_nx;
                            state        <= (vectors_done_nx == num_lat) ? S_DONE : S_FETCH;
                        end
                    end
                    S_DONE: begin
                        mem1_en <= 1'b0;
                        mem2_en <= 1'b0;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state   <= S_IDLE;
                        if (result_valid) begin
                            protocol_err <= 1'b1;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
